sgd_data_loader: RTL and testbench
==================================

Name: sgd_data_loader

Overview:
- Upstream feeder for the SGD trainer core.
- Accepts a host word stream (16-bit, valid/ready) and packs it into DATA_WIDTH rows in a local row RAM: row 0 holds the initial weights, rows 1..data_points hold the samples.
- Serves rows to the trainer on the shared `data`/`addr` bus, holding the trainer in reset while the RAM is being filled.
- On trainer `done`, captures the weight vector from the bus and streams it back to the host.

Parameters:
- ADDR_WIDTH, 12: row address width.
- MAX_FEATURES, 15: feature slots per row.
- LENGTH, 16: word width.
- DATA_WIDTH, LENGTH*(MAX_FEATURES+1): packed row width.
- DP, 1024: maximum samples; RAM depth is DP+1.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin a load/train/drain job
- feat  in  4  features used per sample, 1..MAX_FEATURES; sampled at start
- data_points  in  ADDR_WIDTH  sample count, 1..DP; sampled at start
- s_word  in  LENGTH  host input word
- s_valid  in  1  host word valid
- s_ready  out  1  loader accepts word
- addr  in  ADDR_WIDTH  row address from trainer
- data  inout  DATA_WIDTH  shared row/weight bus
- sgd_done  in  1  trainer completion flag
- sgd_rst  out  1  active-high reset to trainer
- w_word  out  LENGTH  weight output word
- w_valid  out  1  weight word valid
- w_ready  in  1  host accepts weight word
- w_last  out  1  marks W[feat]
- busy  out  1  job in progress
- err  out  1  sticky; bad start parameters

Behaviour:
- Reset (RST_N low, asynchronous) values:
  - state=IDLE; s_ready=0, w_valid=0, w_last=0, busy=0, err=0.
  - sgd_rst=1; data bus released to Z.
  - RAM contents are not reset.
- State machine: IDLE -> FILL -> SERVE -> CAPTURE -> DRAIN -> IDLE.
- IDLE:
  - start with feat==0, feat>MAX_FEATURES (unreachable when MAX_FEATURES=15), data_points==0 or data_points>DP: err<=1, stay IDLE.
  - Otherwise: latch feat and data_points, clear err, clear row/word counters, busy<=1, go to FILL.
  - start outside IDLE is ignored.
- FILL:
  - s_ready=1. A word transfers on s_valid&&s_ready.
  - Word k of a row (k=0..feat) is written into row bits [DATA_WIDTH-1-LENGTH*k -: LENGTH].
  - Row 0 words are W0..W_feat; sample rows are y, x1..x_feat.
  - Slots k>feat are written as zero when the row commits.
  - The row commits to RAM on the cycle its word feat transfers; a row register assembles the row, so RAM sees exactly one write per row.
  - After row data_points commits: s_ready<=0, go to SERVE next cycle.
  - sgd_rst stays 1 throughout FILL.
- SERVE:
  - sgd_rst=0.
  - data = ram[addr] combinationally (asynchronous read) while sgd_done==0; addr > data_points reads row 0.
  - The first clock edge sampling sgd_done==1 moves to CAPTURE.
  - The data driver is released combinationally as soon as sgd_done==1 (same cycle, no contention).
- CAPTURE:
  - Register all of `data` into wcap (trainer is driving it), then go to DRAIN.
  - sgd_rst<=1 to park the trainer.
- DRAIN:
  - w_word = wcap[DATA_WIDTH-1-LENGTH*i -: LENGTH] for i=0..feat; w_valid=1.
  - i advances on w_valid&&w_ready.
  - w_last=1 when i==feat; that handshake returns to IDLE with busy<=0.
  - w_valid holds and w_word stays stable while w_ready is low.
- Reset mid-job: all states abort to IDLE; the next job refills the RAM fully.
- sgd_done high in FILL is ignored: the trainer is held in reset, so a high level there is a glitch.
- Arithmetic: counters only; no wrap, since the row counter stops at data_points ≤ DP.

Decomposition:
- Package sgd_pkg: LENGTH, MAX_FEATURES, ADDR_WIDTH, DATA_WIDTH, DP, and the loader state encodings (IDLE, FILL, SERVE, CAPTURE, DRAIN).
- One sub-module: sgd_row_ram (DP+1 rows × DATA_WIDTH, synchronous write, asynchronous read).

Test Plan:
- feat=2, data_points=3; host sends 12 words:
  - row0 = 1,2,3; rows 1..3 = (10,1,1), (20,2,2), (30,3,3).
  - Expected: s_ready drops after the 12th word; SERVE with addr=2 gives data[255:208] = 20,2,2 and the remaining slots 0; sgd_rst = 1 during FILL and 0 in SERVE.
- Start with data_points=0, then a start with data_points=DP+1 -> err=1, busy=0, s_ready=0 both times; a following valid start clears err.
- SERVE with a model driving 0x0005,0x0007,0xFFFE,… on sgd_done=1:
  - loader releases the bus the same cycle; CAPTURE latches the value.
  - DRAIN (feat=2) emits 5, 7, 0xFFFE with w_last on the third word only.
- w_ready toggled 1,0,0,1,1 during DRAIN -> w_word stable while stalled; exactly feat+1 transfers; busy falls after the last one.
- RST_N pulsed low mid-FILL after 5 words -> outputs return to reset values immediately (asynchronous); a new job completes normally with fresh data.
- s_valid gapped (1,0,1,0,…) across a row boundary -> row committed once, with correct slot packing and no duplicated or skipped words.

Source files
------------

// File: rtl/sgd_pkg.sv
// ============================================================================
// Module      : sgd_pkg
// Description : Shared widths, sizes and loader state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sgd_pkg;
    localparam int ADDR_WIDTH   = 12;
    localparam int MAX_FEATURES = 15;
    localparam int LENGTH       = 16;
    localparam int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1);
    localparam int DP           = 1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        SERVE   = 3'd2,
        CAPTURE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    // Slot 0 lives in the most significant word of a row.
    function automatic int slot_msb(input logic [3:0] k);
        return DATA_WIDTH - 1 - LENGTH * int'(k);
    endfunction
endpackage

`default_nettype wire

// File: rtl/sgd_data_loader_if.sv
// ============================================================================
// Module      : sgd_data_loader_if
// Description : Host-side word streams: sample input and weight output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sgd_data_loader_if;
    import sgd_pkg::*;

    logic [LENGTH-1:0] s_word;
    logic              s_valid;
    logic              s_ready;
    logic [LENGTH-1:0] w_word;
    logic              w_valid;
    logic              w_ready;
    logic              w_last;

    modport master (output s_word, s_valid, w_ready,
                    input  s_ready, w_word, w_valid, w_last);
    modport slave  (input  s_word, s_valid, w_ready,
                    output s_ready, w_word, w_valid, w_last);
endinterface

`default_nettype wire

// File: rtl/sgd_row_ram.sv
// ============================================================================
// Module      : sgd_row_ram
// Description : DP+1 row store, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sgd_row_ram
    import sgd_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  we,
    input  wire logic [ADDR_WIDTH-1:0] waddr,
    input  wire logic [DATA_WIDTH-1:0] wdata,
    input  wire logic [ADDR_WIDTH-1:0] raddr,
    output logic      [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] r_mem [0:DP];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];
endmodule

`default_nettype wire

// File: rtl/sgd_data_loader.sv
// ============================================================================
// Module      : sgd_data_loader
// Description : Fills the row RAM from the host, serves rows to the trainer,
//               then captures and streams the trained weights back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sgd_data_loader
    import sgd_pkg::*;
(
    input  wire logic                  CLK,
    input  wire logic                  RST_N,
    input  wire logic                  start,
    input  wire logic [3:0]            feat,
    input  wire logic [ADDR_WIDTH-1:0] data_points,
    sgd_data_loader_if.slave           host,
    input  wire logic [ADDR_WIDTH-1:0] addr,
    inout  wire       [DATA_WIDTH-1:0] data,
    input  wire logic                  sgd_done,
    output logic                       sgd_rst,
    output logic                       busy,
    output logic                       err
);
    state_t                r_state, w_state_nxt;
    logic [3:0]            r_feat, r_word, r_idx;
    logic [ADDR_WIDTH-1:0] r_dp, r_row, w_rd_addr;
    logic [DATA_WIDTH-1:0] r_rowbuf, r_wcap, w_row_nxt, w_rd_data;
    logic                  r_err, r_sgd_rst;
    logic [4:0]            w_feat_ext;
    logic                  w_bad, w_s_xfer, w_row_done, w_drive;

    assign w_feat_ext = {1'b0, feat};
    assign w_bad      = (feat == 4'd0) || (w_feat_ext > 5'(MAX_FEATURES)) ||
                        (data_points == '0) || (data_points > ADDR_WIDTH'(DP));
    assign w_s_xfer   = host.s_valid && (r_state == FILL);
    assign w_row_done = w_s_xfer && (r_word == r_feat);
    assign w_rd_addr  = (addr > r_dp) ? '0 : addr;

    // Row buffer is cleared between rows, so unused slots commit as zero.
    always_comb begin
        w_row_nxt = r_rowbuf;
        w_row_nxt[slot_msb(r_word) -: LENGTH] = host.s_word;
    end

    always_comb begin
        w_state_nxt  = r_state;
        host.s_ready = 1'b0;
        host.w_valid = 1'b0;
        host.w_last  = 1'b0;
        host.w_word  = r_wcap[slot_msb(r_idx) -: LENGTH];
        w_drive      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !w_bad) w_state_nxt = FILL;
            end
            FILL: begin
                host.s_ready = 1'b1;
                if (w_row_done && (r_row == r_dp)) w_state_nxt = SERVE;
            end
            SERVE: begin
                // Trainer takes the bus the moment it raises done.
                w_drive = !sgd_done;
                if (sgd_done) w_state_nxt = CAPTURE;
            end
            CAPTURE: begin
                w_state_nxt = DRAIN;
            end
            DRAIN: begin
                host.w_valid = 1'b1;
                host.w_last  = (r_idx == r_feat);
                if (host.w_ready && (r_idx == r_feat)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_feat    <= '0;
            r_dp      <= '0;
            r_row     <= '0;
            r_word    <= '0;
            r_idx     <= '0;
            r_rowbuf  <= '0;
            r_wcap    <= '0;
            r_err     <= 1'b0;
            r_sgd_rst <= 1'b1;
        end else begin
            // Trainer runs only while it owns the RAM or is handing back weights.
            r_sgd_rst <= !((w_state_nxt == SERVE) || (w_state_nxt == CAPTURE));
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err    <= 1'b0;
                            r_feat   <= feat;
                            r_dp     <= data_points;
                            r_row    <= '0;
                            r_word   <= '0;
                            r_idx    <= '0;
                            r_rowbuf <= '0;
                        end
                    end
                end
                FILL: begin
                    if (w_s_xfer) begin
                        if (r_word == r_feat) begin
                            r_rowbuf <= '0;
                            r_word   <= '0;
                            if (r_row != r_dp) r_row <= r_row + 1'b1;
                        end else begin
                            r_rowbuf <= w_row_nxt;
                            r_word   <= r_word + 1'b1;
                        end
                    end
                end
                CAPTURE: r_wcap <= data;
                DRAIN: begin
                    if (host.w_ready && (r_idx != r_feat)) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    sgd_row_ram u_ram (
        .clk   (CLK),
        .we    (w_row_done),
        .waddr (r_row),
        .wdata (w_row_nxt),
        .raddr (w_rd_addr),
        .rdata (w_rd_data)
    );

    assign data    = w_drive ? w_rd_data : {DATA_WIDTH{1'bz}};
    assign sgd_rst = r_sgd_rst;
    assign busy    = (r_state != IDLE);
    assign err     = r_err;
endmodule

`default_nettype wire

// File: tb/tb_sgd_data_loader.sv
// ============================================================================
// Module      : tb_sgd_data_loader
// Description : Directed self-checking bench for sgd_data_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sgd_data_loader;
    import sgd_pkg::*;

    logic                  CLK = 1'b0;
    logic                  RST_N = 1'b0;
    logic                  start = 1'b0;
    logic [3:0]            feat = '0;
    logic [ADDR_WIDTH-1:0] data_points = '0;
    logic [ADDR_WIDTH-1:0] addr = '0;
    logic                  sgd_done = 1'b0;
    logic                  tb_drv = 1'b0;
    logic [DATA_WIDTH-1:0] tb_data = '0;
    wire  [DATA_WIDTH-1:0] data;
    logic                  sgd_rst, busy, err;
    int                    n_vec = 0;
    int                    n_fail = 0;

    sgd_data_loader_if host_if ();

    sgd_data_loader dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .start       (start),
        .feat        (feat),
        .data_points (data_points),
        .host        (host_if),
        .addr        (addr),
        .data        (data),
        .sgd_done    (sgd_done),
        .sgd_rst     (sgd_rst),
        .busy        (busy),
        .err         (err)
    );

    assign data = tb_drv ? tb_data : {DATA_WIDTH{1'bz}};

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_job(input logic [3:0] f, input logic [ADDR_WIDTH-1:0] d);
        start = 1'b1; feat = f; data_points = d;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit gap);
        int t = 0;
        host_if.s_valid = 1'b1;
        host_if.s_word  = w;
        while (!host_if.s_ready && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) begin
            n_vec++; n_fail++;
            $display("FAIL send_timeout: s_ready stayed %0b, wanted 1", host_if.s_ready);
        end
        tick();
        host_if.s_valid = 1'b0;
        if (gap) tick();
    endtask

    task automatic finish_job(input logic [DATA_WIDTH-1:0] wts);
        int t = 0;
        tb_data = wts; tb_drv = 1'b1; sgd_done = 1'b1;
        tick();
        tick();
        tb_drv = 1'b0; sgd_done = 1'b0; host_if.w_ready = 1'b1;
        while (busy && t < 40) begin
            tick();
            t++;
        end
        host_if.w_ready = 1'b0;
        if (t >= 40) begin
            n_vec++; n_fail++;
            $display("FAIL drain_timeout: busy=%0b, wanted 0", busy);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #12;
        n_vec++; if (host_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", host_if.s_ready); end
        n_vec++; if (host_if.w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_w_valid: got %b want 0", host_if.w_valid); end
        n_vec++; if (host_if.w_last !== 1'b0) begin n_fail++; $display("FAIL reset_w_last: got %b want 0", host_if.w_last); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_vec++; if (sgd_rst !== 1'b1) begin n_fail++; $display("FAIL reset_sgd_rst: got %b want 1", sgd_rst); end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_fill_serve();
        logic [15:0] words [12] = '{16'd1, 16'd2, 16'd3, 16'd10, 16'd1, 16'd1,
                                    16'd20, 16'd2, 16'd2, 16'd30, 16'd3, 16'd3};
        start_job(4'd2, 12'd3);
        n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy: got %b want 1", busy); end
        for (int i = 0; i < 11; i++) send_word(words[i], 1'b0);
        n_vec++; if (host_if.s_ready !== 1'b1) begin n_fail++; $display("FAIL fill_s_ready_before_last: got %b want 1", host_if.s_ready); end
        n_vec++; if (sgd_rst !== 1'b1) begin n_fail++; $display("FAIL fill_sgd_rst: got %b want 1", sgd_rst); end
        send_word(words[11], 1'b0);
        n_vec++; if (host_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL serve_s_ready: got %b want 0", host_if.s_ready); end
        n_vec++; if (sgd_rst !== 1'b0) begin n_fail++; $display("FAIL serve_sgd_rst: got %b want 0", sgd_rst); end
        addr = 12'd2; #1;
        n_vec++; if (data[255:208] !== 48'h0014_0002_0002) begin n_fail++; $display("FAIL serve_row2: got %h want 001400020002", data[255:208]); end
        n_vec++; if (data[207:0] !== '0) begin n_fail++; $display("FAIL serve_row2_tail: got %h want 0", data[207:0]); end
        addr = 12'd3; #1;
        n_vec++; if (data[255:208] !== 48'h001E_0003_0003) begin n_fail++; $display("FAIL serve_row3: got %h want 001e00030003", data[255:208]); end
        addr = 12'd7; #1;
        n_vec++; if (data[255:208] !== 48'h0001_0002_0003) begin n_fail++; $display("FAIL serve_oob_row0: got %h want 000100020003", data[255:208]); end
    endtask

    task automatic test_capture_drain();
        logic [15:0] exp_w [3] = '{16'h0005, 16'h0007, 16'hFFFE};
        bit          rdy   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int          k = 0;
        addr    = 12'd0;
        tb_data = {16'h0005, 16'h0007, 16'hFFFE, 16'h1234, 192'd0};
        tb_drv  = 1'b1; sgd_done = 1'b1;
        #1;
        n_vec++; if (data !== tb_data) begin n_fail++; $display("FAIL release_bus: got %h want %h", data[255:192], tb_data[255:192]); end
        tick();
        tick();
        tb_drv = 1'b0; sgd_done = 1'b0;
        n_vec++; if (sgd_rst !== 1'b1) begin n_fail++; $display("FAIL drain_sgd_rst: got %b want 1", sgd_rst); end
        for (int c = 0; c < 5; c++) begin
            host_if.w_ready = rdy[c];
            #1;
            n_vec++; if (host_if.w_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid_c%0d: got %b want 1", c, host_if.w_valid); end
            n_vec++; if (host_if.w_word !== exp_w[k]) begin n_fail++; $display("FAIL drain_word_c%0d: got %h want %h", c, host_if.w_word, exp_w[k]); end
            n_vec++; if (host_if.w_last !== (k == 2)) begin n_fail++; $display("FAIL drain_last_c%0d: got %b want %b", c, host_if.w_last, (k == 2)); end
            tick();
            if (rdy[c]) k++;
        end
        host_if.w_ready = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_busy_end: got %b want 0", busy); end
        n_vec++; if (host_if.w_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid_end: got %b want 0", host_if.w_valid); end
    endtask

    task automatic test_bad_params();
        start_job(4'd2, 12'd0);
        n_vec++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_dp0_err: got %b want 1", err); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_dp0_busy: got %b want 0", busy); end
        n_vec++; if (host_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL bad_dp0_s_ready: got %b want 0", host_if.s_ready); end
        start_job(4'd2, 12'(DP + 1));
        n_vec++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_dpmax_err: got %b want 1", err); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_dpmax_busy: got %b want 0", busy); end
        n_vec++; if (host_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL bad_dpmax_s_ready: got %b want 0", host_if.s_ready); end
        start_job(4'd1, 12'd2);
        n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL good_err_clear: got %b want 0", err); end
        n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL good_busy: got %b want 1", busy); end
    endtask

    task automatic test_gapped_rows();
        logic [15:0] words [6] = '{16'h000A, 16'h000B, 16'h0011, 16'h0012, 16'h0021, 16'h0022};
        for (int i = 0; i < 5; i++) send_word(words[i], 1'b1);
        n_vec++; if (host_if.s_ready !== 1'b1) begin n_fail++; $display("FAIL gap_s_ready_before_last: got %b want 1", host_if.s_ready); end
        send_word(words[5], 1'b1);
        n_vec++; if (host_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL gap_s_ready_after: got %b want 0", host_if.s_ready); end
        addr = 12'd1; #1;
        n_vec++; if (data[255:224] !== 32'h0011_0012) begin n_fail++; $display("FAIL gap_row1: got %h want 00110012", data[255:224]); end
        n_vec++; if (data[223:0] !== '0) begin n_fail++; $display("FAIL gap_row1_tail: got %h want 0", data[223:0]); end
        addr = 12'd2; #1;
        n_vec++; if (data[255:224] !== 32'h0021_0022) begin n_fail++; $display("FAIL gap_row2: got %h want 00210022", data[255:224]); end
        addr = 12'd0; #1;
        n_vec++; if (data[255:224] !== 32'h000A_000B) begin n_fail++; $display("FAIL gap_row0: got %h want 000a000b", data[255:224]); end
        finish_job({16'h0001, 16'h0002, 224'd0});
    endtask

    task automatic test_reset_mid_fill();
        logic [15:0] words [6] = '{16'd7, 16'd8, 16'd9, 16'd100, 16'd200, 16'd300};
        start_job(4'd2, 12'd3);
        for (int i = 0; i < 5; i++) send_word(16'h00F0 + 16'(i), 1'b0);
        #3;
        RST_N = 1'b0;
        #1;
        n_vec++; if (host_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL arst_s_ready: got %b want 0", host_if.s_ready); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
        n_vec++; if (sgd_rst !== 1'b1) begin n_fail++; $display("FAIL arst_sgd_rst: got %b want 1", sgd_rst); end
        #7;
        RST_N = 1'b1;
        tick();
        start_job(4'd2, 12'd1);
        for (int i = 0; i < 6; i++) send_word(words[i], 1'b0);
        n_vec++; if (host_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL rejob_s_ready: got %b want 0", host_if.s_ready); end
        addr = 12'd1; #1;
        n_vec++; if (data[255:208] !== 48'h0064_00C8_012C) begin n_fail++; $display("FAIL rejob_row1: got %h want 006400c8012c", data[255:208]); end
        addr = 12'd0; #1;
        n_vec++; if (data[255:208] !== 48'h0007_0008_0009) begin n_fail++; $display("FAIL rejob_row0: got %h want 000700080009", data[255:208]); end
        finish_job({16'h0003, 16'h0004, 16'h0005, 208'd0});
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rejob_done_busy: got %b want 0", busy); end
    endtask

    initial begin
        host_if.s_valid = 1'b0;
        host_if.s_word  = '0;
        host_if.w_ready = 1'b0;
        test_reset();
        test_fill_serve();
        test_capture_drain();
        test_bad_params();
        test_gapped_rows();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

`default_nettype wire
